// File: rtl/nes_loader_pkg.sv
// Shared constants for the game loader: FSM state encoding and the fixed
// widths of the RAM address, byte counter and game index.
package nes_loader_pkg;

    localparam int ADDR_W = 19;   // PRG/CHR RAM address width
    localparam int CNT_W  = 20;   // load byte counter width
    localparam int IDX_W  = 4;    // game slot index width

    localparam logic [2:0] ST_RELOAD = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debouncer.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   btn_i         - raw asynchronous button level
//   rise_o        - one-cycle pulse on the debounced rising edge
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive synchronized samples that disagree with the
    // debounced level; the level flips only once that run is long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/game_load_sequencer.sv
// Game load sequencer: selects a game slot with next/prev buttons, restarts
// the flash byte loader, copies LOAD_BYTES bytes into RAM, holds the console
// in reset while loading/settling and flags a stalled loader as an error.
// Ports:
//   clock, reset               - system clock, synchronous active-high reset
//   btn_next, btn_prev         - raw buttons (next / previous game)
//   loader_reload/index        - restart pulse and slot for the byte loader
//   loader_data/valid          - byte stream from the loader
//   ram_waddr/wdata/we         - RAM write port
//   nes_reset                  - console reset, low only while running
//   cur_index                  - selected slot
//   load_busy, load_error      - status
module game_load_sequencer
    import nes_loader_pkg::*;
#(
    parameter int NUM_GAMES       = 16,
    parameter int LOAD_BYTES      = 524288,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WATCHDOG_CYCLES = 16777215,
    parameter int SETTLE_CYCLES   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    output logic              loader_reload,
    output logic [IDX_W-1:0]  loader_index,
    input  logic [7:0]        loader_data,
    input  logic              loader_valid,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              nes_reset,
    output logic [IDX_W-1:0]  cur_index,
    output logic              load_busy,
    output logic              load_error
);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LOAD_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_GAMES - 1);

    logic ev_next, ev_prev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock(clock), .reset(reset), .btn_i(btn_next), .rise_o(ev_next)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clock(clock), .reset(reset), .btn_i(btn_prev), .rise_o(ev_prev)
    );

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ST_W-1:0]   st_q, st_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        st_d    = st_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_RELOAD: begin
                cnt_d   = '0;
                wd_d    = '0;
                st_d    = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (loader_valid) begin
                    // Write is issued from registers one cycle after capture.
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = loader_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    wd_d    = '0;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_SETTLE;
                        st_d    = '0;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_SETTLE: begin
                if (st_q == ST_LAST) state_d = ST_RUN;
                else                 st_d    = st_q + ST_W'(1);
            end
            ST_RUN, ST_ERROR: begin
                // Exactly one event acts; a simultaneous pair cancels out.
                if (ev_next ^ ev_prev) begin
                    state_d = ST_RELOAD;
                    if (ev_next) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    else         idx_d = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
                end
            end
            default: state_d = ST_RELOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RELOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            st_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            st_q    <= st_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs are forced to their idle values while reset is high so that a
    // reset arriving mid-load stops writes in the very cycle it is asserted.
    assign loader_reload = (state_q == ST_RELOAD) & ~reset;
    assign loader_index  = reset ? '0 : idx_q;
    assign cur_index     = reset ? '0 : idx_q;
    assign ram_we        = we_q & ~reset;
    assign ram_waddr     = waddr_q;
    assign ram_wdata     = wdata_q;
    assign nes_reset     = (state_q != ST_RUN) | reset;
    assign load_busy     = (state_q == ST_RELOAD) | (state_q == ST_LOAD) |
                           (state_q == ST_SETTLE) | reset;
    assign load_error    = (state_q == ST_ERROR) & ~reset;

endmodule

// File: tb/tb_game_load_sequencer.sv
// Scoreboard bench for game_load_sequencer with small parameters.
module tb_game_load_sequencer;
    localparam int NG = 3, LB = 16, DB = 4, WD = 64, SC = 4;

    logic        clock = 1'b0, reset = 1'b1;
    logic        btn_next = 1'b0, btn_prev = 1'b0;
    logic        loader_valid = 1'b0;
    logic [7:0]  loader_data = 8'h00;
    logic        loader_reload, ram_we, nes_reset, load_busy, load_error;
    logic [3:0]  loader_index, cur_index;
    logic [18:0] ram_waddr;
    logic [7:0]  ram_wdata;

    game_load_sequencer #(
        .NUM_GAMES(NG), .LOAD_BYTES(LB), .DEBOUNCE_CYCLES(DB),
        .WATCHDOG_CYCLES(WD), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .loader_reload(loader_reload), .loader_index(loader_index),
        .loader_data(loader_data), .loader_valid(loader_valid),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .nes_reset(nes_reset), .cur_index(cur_index),
        .load_busy(load_busy), .load_error(load_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [3:0]  idx;
        logic [18:0] addr;
        logic [7:0]  data;
    } exp_t;
    exp_t exp_q[$];

    int vecs = 0, errs = 0;
    int m_idx = 0;      // model: selected slot
    bit m_live = 0;     // model: console running or in error (buttons act)

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_reload(input int idx);
        exp_t e;
        e.wr = 1'b0; e.idx = 4'(idx); e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_write(input int addr, input logic [7:0] data);
        exp_t e;
        e.wr = 1'b1; e.idx = '0; e.addr = 19'(addr); e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a reload or write.
    exp_t m_e;
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_ram_we", int'(ram_we), 0);
            chk("rst_reload", int'(loader_reload), 0);
            chk("rst_nes_reset", int'(nes_reset), 1);
            chk("rst_busy", int'(load_busy), 1);
            chk("rst_error", int'(load_error), 0);
            chk("rst_cur_index", int'(cur_index), 0);
        end else begin
            if (loader_reload) begin
                if (exp_q.size() == 0 || exp_q[0].wr) chk("unexpected_reload", 1, 0);
                else begin
                    m_e = exp_q.pop_front();
                    chk("reload_index", int'(loader_index), int'(m_e.idx));
                end
            end
            if (ram_we) begin
                if (exp_q.size() == 0 || !exp_q[0].wr) chk("unexpected_write", int'(ram_waddr), -1);
                else begin
                    m_e = exp_q.pop_front();
                    chk("wr_addr", int'(ram_waddr), int'(m_e.addr));
                    chk("wr_data", int'(ram_wdata), int'(m_e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic wait_reload();
        int n = 0;
        #1;
        while (!loader_reload && n < 30) begin
            @(posedge clock); #2; n++;
        end
        chk("reload_seen", int'(n < 30), 1);
        chk("reload_nes_reset", int'(nes_reset), 1);
        chk("reload_busy", int'(load_busy), 1);
    endtask

    // Loader model: one junk byte during the reload cycle (must be ignored),
    // then n bytes; only the first npush are expected to reach RAM.
    task automatic feed(input int n, input bit rnd, input int npush, output int c_last);
        c_last = cyc;
        loader_valid = 1'b1; loader_data = 8'hEE;
        tick();
        loader_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = rnd ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) tick();
            loader_valid = 1'b1;
            loader_data  = rnd ? 8'($urandom) : 8'(i);
            if (i < npush && i < LB) push_write(i, loader_data);
            tick();
            loader_valid = 1'b0;
            if (i == LB - 1 || (i == n - 1 && n < LB)) c_last = cyc;
        end
    endtask

    task automatic wait_run(input int c_last);
        int n = 0;
        while (nes_reset && n < 200) begin tick(); n++; end
        chk("run_reached", int'(nes_reset), 0);
        chk("settle_len", cyc - c_last, SC);
        chk("run_busy", int'(load_busy), 0);
        chk("run_index", int'(cur_index), m_idx);
        m_live = 1;
    endtask

    task automatic wait_err(input int c_last);
        int n = 0;
        while (!load_error && n < 200) begin tick(); n++; end
        chk("error_flag", int'(load_error), 1);
        chk("watchdog_len", cyc - c_last, WD);
        chk("error_nes_reset", int'(nes_reset), 1);
        chk("error_busy", int'(load_busy), 0);
        m_live = 1;
    endtask

    // Button model: a press held at least DB cycles is one event; it acts
    // only while running/errored and only if exactly one button moved.
    task automatic press(input bit nx, input bit pv, input int hold);
        if (m_live && hold >= DB && (nx ^ pv)) begin
            m_idx  = nx ? (m_idx + 1) % NG : (m_idx + NG - 1) % NG;
            m_live = 0;
            push_reload(m_idx);
        end
        btn_next = nx; btn_prev = pv;
        repeat (hold) tick();
        btn_next = 1'b0; btn_prev = 1'b0;
    endtask

    task automatic switch_and_load(input bit nx, input int hold);
        int c;
        fork press(nx, ~nx, hold); join_none
        wait_reload();
        feed(LB, 1'b1, LB, c);
        wait_run(c);
    endtask

    initial begin
        int c;
        repeat (4) tick();
        // Boot load of slot 0: 18 bytes 0x00..0x11, the last two overrun.
        push_reload(0);
        reset = 1'b0;
        wait_reload();
        feed(LB + 2, 1'b0, LB, c);
        wait_run(c);

        // prev from 0 wraps to 2, then a short glitch does nothing.
        switch_and_load(1'b0, 6);
        press(1'b1, 1'b0, 2);
        repeat (12) tick();
        chk("glitch_index", int'(cur_index), m_idx);
        chk("glitch_running", int'(nes_reset), 0);
        // next held 10 cycles from 2 wraps to 0.
        switch_and_load(1'b1, 10);

        // Loader stalls after 5 bytes -> watchdog error; next recovers.
        fork press(1'b1, 1'b0, 6); join_none
        wait_reload();
        feed(5, 1'b1, 5, c);
        wait_err(c);
        switch_and_load(1'b1, 6);

        // next pressed during a load is dropped.
        fork press(1'b0, 1'b1, 6); join_none
        wait_reload();
        fork press(1'b1, 1'b0, 6); join_none
        feed(LB, 1'b1, LB, c);
        wait_run(c);
        repeat (12) tick();
        chk("busy_press_index", int'(cur_index), m_idx);

        // Both buttons together cancel.
        press(1'b1, 1'b1, 6);
        repeat (12) tick();
        chk("dual_index", int'(cur_index), m_idx);
        chk("dual_running", int'(nes_reset), 0);

        // Random switching with random glitches in between.
        for (int k = 0; k < 5; k++) begin
            switch_and_load(1'($urandom), int'($urandom_range(6, 9)));
            repeat (10) tick();
            press(1'($urandom), 1'($urandom), int'($urandom_range(1, 2)));
            repeat (12) tick();
            chk("rand_glitch_index", int'(cur_index), m_idx);
        end

        // Reset arrives with byte 7: byte 6's write would fall in the reset
        // cycle and is lost; a fresh boot load of slot 0 follows.
        fork press(1'b1, 1'b0, 6); join_none
        wait_reload();
        feed(7, 1'b1, 6, c);
        loader_valid = 1'b1; loader_data = 8'h77; reset = 1'b1;
        repeat (3) tick();
        loader_valid = 1'b0;
        chk("reset_queue_empty", exp_q.size(), 0);
        m_idx = 0; m_live = 0;
        push_reload(0);
        reset = 1'b0;
        wait_reload();
        feed(LB, 1'b1, LB, c);
        wait_run(c);

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
